// File: rtl/if_fetch_ctrl_pkg.sv
// Shared definitions for the instruction-fetch controller.
//   state_e         : fetch sequencer states
//   ResetPcDefault  : default fetch address after reset
//   ZeroWord        : 32-bit zero used for register reset values
//   align_pc()      : forces a byte address onto a word boundary
package if_fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StHold = 2'd2
    } state_e;

    localparam logic [31:0] ResetPcDefault = 32'h0000_0000;
    localparam logic [31:0] ZeroWord       = 32'h0000_0000;

    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/if_fetch_ctrl_if.sv
// Instruction-memory request/response bundle.
//   req   : fetch request (master -> slave)
//   addr  : word-aligned fetch address, stable while req & !ack
//   ack   : response valid this cycle, may coincide with the first req cycle
//   rdata : instruction word, valid with ack
interface if_fetch_ctrl_if;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] rdata;

    modport master (output req, output addr, input  ack, input  rdata);
    modport slave  (input  req, input  addr, output ack, output rdata);
endinterface

// File: rtl/if_skid_buf.sv
// One-entry {pc, inst} holding register used when a response arrives while
// the output slot is full and stalled.
//   load_i  : capture pc_i/inst_i and mark valid
//   drain_i : entry has been moved out, mark empty
//   clear_i : discard the entry (highest priority)
//   valid_o/pc_o/inst_o : registered entry contents
module if_skid_buf
    import if_fetch_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_i,
    input  logic        drain_i,
    input  logic        clear_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] inst_i,
    output logic        valid_o,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o
);

    logic        valid_q, valid_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;

    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        if (clear_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = 1'b1;
            pc_d    = pc_i;
            inst_d  = inst_i;
        end else if (drain_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            pc_q    <= ZeroWord;
            inst_q  <= ZeroWord;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
        end
    end

    assign valid_o = valid_q;
    assign pc_o    = pc_q;
    assign inst_o  = inst_q;

endmodule

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, issues imem requests, applies
// branch redirects (cancelling an in-flight fetch) and buffers fetched words
// in an output slot backed by a one-entry skid register across stalls.
//   clk, rst_n               : clock, asynchronous active-low reset
//   branch_flag_i            : redirect request from decode
//   branch_target_address_i  : redirect target, low two bits ignored
//   stall_i                  : downstream cannot accept the slot
//   imem                     : instruction-memory request port (master)
//   if_valid_o/pc_o/inst_o   : registered output slot towards IF/ID
module if_fetch_ctrl
    import if_fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = ResetPcDefault
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            branch_flag_i,
    input  logic [31:0]     branch_target_address_i,
    input  logic            stall_i,
    if_fetch_ctrl_if.master imem,
    output logic            if_valid_o,
    output logic [31:0]     if_pc_o,
    output logic [31:0]     if_inst_o
);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    // kill_q marks the outstanding request as cancelled; kill_addr_q keeps its
    // address on the bus until the ack retires it, while pc_q already holds
    // the redirect target.
    logic        kill_q, kill_d;
    logic [31:0] kill_addr_q, kill_addr_d;
    logic        slot_valid_q, slot_valid_d;
    logic [31:0] slot_pc_q, slot_pc_d;
    logic [31:0] slot_inst_q, slot_inst_d;

    logic        skid_load, skid_drain, skid_clear;
    logic        skid_valid;
    logic [31:0] skid_pc, skid_inst;
    logic        consumed;

    if_skid_buf u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (skid_load),
        .drain_i (skid_drain),
        .clear_i (skid_clear),
        .pc_i    (pc_q),
        .inst_i  (imem.rdata),
        .valid_o (skid_valid),
        .pc_o    (skid_pc),
        .inst_o  (skid_inst)
    );

    assign consumed = slot_valid_q & ~stall_i;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        kill_d       = kill_q;
        kill_addr_d  = kill_addr_q;
        slot_valid_d = slot_valid_q;
        slot_pc_d    = slot_pc_q;
        slot_inst_d  = slot_inst_q;
        skid_load    = 1'b0;
        skid_drain   = 1'b0;
        skid_clear   = 1'b0;

        unique case (state_q)
            StIdle: begin
                state_d = StReq;
            end
            StReq: begin
                if (branch_flag_i) begin
                    pc_d         = align_pc(branch_target_address_i);
                    slot_valid_d = 1'b0;
                    skid_clear   = 1'b1;
                    if (imem.ack) begin
                        // Response retires the outstanding request and is dropped.
                        kill_d = 1'b0;
                    end else if (!kill_q) begin
                        kill_d      = 1'b1;
                        kill_addr_d = pc_q;
                    end
                end else if (imem.ack) begin
                    if (kill_q) begin
                        kill_d = 1'b0;
                        if (consumed) begin
                            slot_valid_d = 1'b0;
                        end
                    end else if (!slot_valid_q || !stall_i) begin
                        slot_valid_d = 1'b1;
                        slot_pc_d    = pc_q;
                        slot_inst_d  = imem.rdata;
                        pc_d         = pc_q + 32'd4;
                    end else begin
                        skid_load = 1'b1;
                        pc_d      = pc_q + 32'd4;
                        state_d   = StHold;
                    end
                end else if (consumed) begin
                    slot_valid_d = 1'b0;
                end
            end
            StHold: begin
                // No request is outstanding here, so a branch never needs a kill.
                if (branch_flag_i) begin
                    pc_d         = align_pc(branch_target_address_i);
                    slot_valid_d = 1'b0;
                    skid_clear   = 1'b1;
                    state_d      = StReq;
                end else if (!stall_i) begin
                    slot_valid_d = skid_valid;
                    slot_pc_d    = skid_pc;
                    slot_inst_d  = skid_inst;
                    skid_drain   = 1'b1;
                    state_d      = StReq;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            pc_q         <= align_pc(RESET_PC);
            kill_q       <= 1'b0;
            kill_addr_q  <= ZeroWord;
            slot_valid_q <= 1'b0;
            slot_pc_q    <= ZeroWord;
            slot_inst_q  <= ZeroWord;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            kill_q       <= kill_d;
            kill_addr_q  <= kill_addr_d;
            slot_valid_q <= slot_valid_d;
            slot_pc_q    <= slot_pc_d;
            slot_inst_q  <= slot_inst_d;
        end
    end

    assign imem.req  = (state_q == StReq);
    assign imem.addr = kill_q ? kill_addr_q : pc_q;

    assign if_valid_o = slot_valid_q;
    assign if_pc_o    = slot_pc_q;
    assign if_inst_o  = slot_inst_q;

endmodule
